// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: shared constants, packet type and byte0 decode for the PS/2 mouse sequencer.
package ps2_mouse_pkg;
    localparam logic [1:0] ST_SEND = 2'd0, ST_ACK = 2'd1, ST_STREAM = 2'd2, ST_FAIL = 2'd3;
    localparam logic [7:0] CMD_ENABLE = 8'hF4, RSP_ACK = 8'hFA;
    localparam int B0_SYNC = 3, B0_XSIGN = 4, B0_YSIGN = 5, B0_XOVF = 6, B0_YOVF = 7;

    typedef struct packed {
        logic [2:0] buttons;
        logic [8:0] dx;
        logic [8:0] dy;
        logic       x_ovf;
        logic       y_ovf;
    } pkt_t;

    function automatic pkt_t decode_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        decode_pkt = '{buttons: b0[2:0], dx: {b0[B0_XSIGN], b1}, dy: {b0[B0_YSIGN], b2},
                       x_ovf: b0[B0_XOVF], y_ovf: b0[B0_YOVF]};
    endfunction
endpackage

// File: rtl/ps2_mouse_pos_accum.sv
// ps2_mouse_pos_accum: saturating cursor integrator; x adds dx, y subtracts dy (screen y grows downward).
module ps2_mouse_pos_accum #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic       i_clock_50,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic [8:0] i_dx,
    input  logic [8:0] i_dy,
    input  logic       i_x_ovf,
    input  logic       i_y_ovf,
    output logic [8:0] o_pos_x,
    output logic [7:0] o_pos_y
);
    localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - 1);
    localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - 1);
    logic [8:0] r_x;
    logic [7:0] r_y;
    logic signed [10:0] w_nx, w_ny;
    assign w_nx = $signed({2'b00, r_x}) + $signed({{2{i_dx[8]}}, i_dx});
    assign w_ny = $signed({3'b000, r_y}) - $signed({{2{i_dy[8]}}, i_dy});
    always_ff @(posedge i_clock_50) begin
        if (i_reset) begin
            r_x <= 9'(SCREEN_W / 2);
            r_y <= 8'(SCREEN_H / 2);
        end else if (i_valid) begin
            if (!i_x_ovf) r_x <= w_nx < 0 ? 9'd0 : w_nx > X_MAX ? X_MAX[8:0] : w_nx[8:0];
            if (!i_y_ovf) r_y <= w_ny < 0 ? 8'd0 : w_ny > Y_MAX ? Y_MAX[7:0] : w_ny[7:0];
        end
    end
    assign o_pos_x = r_x;
    assign o_pos_y = r_y;
endmodule

// File: rtl/ps2_mouse_sequencer.sv
// ps2_mouse_sequencer: enables PS/2 mouse reporting (0xF4, ACK with retry) then frames 3-byte packets.
// Define PS2_MOUSE_POS_EN to build the clamped cursor integrator; otherwise pos outputs hold centre.
module ps2_mouse_sequencer
    import ps2_mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int INIT_ATTEMPTS  = 3,
    parameter int SCREEN_W       = 320,
    parameter int SCREEN_H       = 240
) (
    input  logic       i_clock_50,
    input  logic       i_reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_data_en,
    output logic [7:0] o_cmd_data,
    output logic       o_cmd_send,
    input  logic       i_cmd_sent,
    input  logic       i_cmd_timeout,
    output logic       o_ready,
    output logic       o_init_fail,
    output logic       o_pkt_valid,
    output logic [2:0] o_buttons,
    output logic [8:0] o_dx,
    output logic [8:0] o_dy,
    output logic       o_x_ovf,
    output logic       o_y_ovf,
    output logic       o_sync_err,
    output logic [8:0] o_pos_x,
    output logic [7:0] o_pos_y
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(INIT_ATTEMPTS + 1);
    logic [1:0]    r_state, r_idx;
    logic [AW-1:0] r_attempts;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_b0, r_b1;
    logic          r_cmd_send, r_pkt_valid, r_sync_err;
    pkt_t          r_pkt;
    logic          w_timer_done, w_fail;
    logic [AW-1:0] w_attempts_next;

    assign w_timer_done    = r_timer == TW'(TIMEOUT_CYCLES);
    assign w_attempts_next = r_attempts + 1'b1;
    // cmd_sent wins over a simultaneous cmd_timeout; a byte in ACK wins over the timer
    assign w_fail = (r_state == ST_SEND && r_cmd_send && !i_cmd_sent && i_cmd_timeout) ||
                    (r_state == ST_ACK && (i_rx_data_en ? i_rx_data != RSP_ACK : w_timer_done));

    always_ff @(posedge i_clock_50) begin
        if (i_reset || r_state == ST_SEND || i_rx_data_en) r_timer <= '0;
        else if (!w_timer_done) r_timer <= r_timer + 1'b1;
    end

    always_ff @(posedge i_clock_50) begin
        if (i_reset) begin
            r_state     <= ST_SEND;
            r_attempts  <= '0;
            r_cmd_send  <= 1'b0;
            r_idx       <= 2'd0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_pkt       <= '0;
            r_pkt_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_pkt_valid <= 1'b0;
            r_sync_err  <= 1'b0;
            if (w_fail) begin
                r_attempts <= w_attempts_next;
                r_state    <= w_attempts_next == AW'(INIT_ATTEMPTS) ? ST_FAIL : ST_SEND;
                r_cmd_send <= 1'b0;
            end else if (r_state == ST_SEND) begin
                r_cmd_send <= !(r_cmd_send && i_cmd_sent);
                if (r_cmd_send && i_cmd_sent) r_state <= ST_ACK;
            end else if (r_state == ST_ACK) begin
                if (i_rx_data_en) r_state <= ST_STREAM;
            end else if (r_state == ST_STREAM) begin
                if (i_rx_data_en) begin
                    if (r_idx == 2'd0) begin
                        r_b0       <= i_rx_data;
                        r_idx      <= i_rx_data[B0_SYNC] ? 2'd1 : 2'd0;
                        r_sync_err <= !i_rx_data[B0_SYNC];
                    end else if (r_idx == 2'd1) begin
                        r_b1  <= i_rx_data;
                        r_idx <= 2'd2;
                    end else begin
                        r_pkt       <= decode_pkt(r_b0, r_b1, i_rx_data);
                        r_pkt_valid <= 1'b1;
                        r_idx       <= 2'd0;
                    end
                end else if (r_idx != 2'd0 && w_timer_done) begin
                    r_idx      <= 2'd0;
                    r_sync_err <= 1'b1;
                end
            end
        end
    end

    assign o_cmd_data  = CMD_ENABLE;
    assign o_cmd_send  = r_cmd_send;
    assign o_ready     = r_state == ST_STREAM;
    assign o_init_fail = r_state == ST_FAIL;
    assign o_pkt_valid = r_pkt_valid;
    assign o_sync_err  = r_sync_err;
    assign o_buttons   = r_pkt.buttons;
    assign o_dx        = r_pkt.dx;
    assign o_dy        = r_pkt.dy;
    assign o_x_ovf     = r_pkt.x_ovf;
    assign o_y_ovf     = r_pkt.y_ovf;

`ifdef PS2_MOUSE_POS_EN
    ps2_mouse_pos_accum #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_pos (
        .i_clock_50(i_clock_50),
        .i_reset   (i_reset),
        .i_valid   (r_pkt_valid),
        .i_dx      (r_pkt.dx),
        .i_dy      (r_pkt.dy),
        .i_x_ovf   (r_pkt.x_ovf),
        .i_y_ovf   (r_pkt.y_ovf),
        .o_pos_x   (o_pos_x),
        .o_pos_y   (o_pos_y)
    );
`else
    assign o_pos_x = 9'(SCREEN_W / 2);
    assign o_pos_y = 8'(SCREEN_H / 2);
`endif
endmodule

// File: tb/tb_ps2_mouse_sequencer.sv
// tb_ps2_mouse_sequencer: directed bring-up/retry checks plus a packet scoreboard drained by a negedge monitor.
module tb_ps2_mouse_sequencer;
    localparam int T = 40;
    logic clk = 1'b0, rst = 1'b1, rx_en = 1'b0, cmd_sent = 1'b0, cmd_to = 1'b0;
    logic [7:0] rx = 8'h00;
    logic [7:0] cmd_data;
    logic cmd_send, ready, init_fail, pkt_valid, x_ovf, y_ovf, sync_err;
    logic [2:0] buttons;
    logic [8:0] dx, dy, pos_x;
    logic [7:0] pos_y;
    int n_chk = 0, n_err = 0, exp_sync = 0, got_sync = 0, k;

    typedef struct packed {
        logic [2:0] b;
        logic [8:0] dx;
        logic [8:0] dy;
        logic       xo;
        logic       yo;
        logic [8:0] px;
        logic [7:0] py;
    } exp_t;
    exp_t q[$];
    exp_t cur;
    logic pos_pend = 1'b0;

    always #5 clk = ~clk;

    ps2_mouse_sequencer #(.TIMEOUT_CYCLES(T), .INIT_ATTEMPTS(3), .SCREEN_W(320), .SCREEN_H(240)) dut (
        .i_clock_50(clk), .i_reset(rst), .i_rx_data(rx), .i_rx_data_en(rx_en),
        .o_cmd_data(cmd_data), .o_cmd_send(cmd_send), .i_cmd_sent(cmd_sent), .i_cmd_timeout(cmd_to),
        .o_ready(ready), .o_init_fail(init_fail), .o_pkt_valid(pkt_valid), .o_buttons(buttons),
        .o_dx(dx), .o_dy(dy), .o_x_ovf(x_ovf), .o_y_ovf(y_ovf), .o_sync_err(sync_err),
        .o_pos_x(pos_x), .o_pos_y(pos_y)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx = b;
        rx_en = 1'b1;
        tick();
        rx_en = 1'b0;
    endtask

    task automatic push(input logic [2:0] eb, input logic [8:0] edx, input logic [8:0] edy,
                        input logic exo, input logic eyo, input logic [8:0] epx, input logic [7:0] epy);
        q.push_back('{eb, edx, edy, exo, eyo, epx, epy});
    endtask

    task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [2:0] eb, input logic [8:0] edx, input logic [8:0] edy,
                       input logic exo, input logic eyo, input logic [8:0] epx, input logic [7:0] epy);
        push(eb, edx, edy, exo, eyo, epx, epy);
        send(b0);
        send(b1);
        send(b2);
    endtask

    task automatic wait_send();
        int n = 0;
        while (!cmd_send && n < 5) begin
            tick();
            n++;
        end
        chk("wait_cmd_send", cmd_send, 1);
    endtask

    always @(negedge clk) begin
        if (pos_pend) begin
`ifdef PS2_MOUSE_POS_EN
            chk("pos_x", pos_x, cur.px);
            chk("pos_y", pos_y, cur.py);
`else
            chk("pos_x_hold", pos_x, 160);
            chk("pos_y_hold", pos_y, 120);
`endif
            pos_pend = 1'b0;
        end
        if (sync_err) got_sync++;
        if (pkt_valid) begin
            if (q.size() == 0) chk("pkt_unexpected", 1, 0);
            else begin
                cur = q.pop_front();
                chk("buttons", buttons, cur.b);
                chk("dx", dx, cur.dx);
                chk("dy", dy, cur.dy);
                chk("ovf", {x_ovf, y_ovf}, {cur.xo, cur.yo});
                pos_pend = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tick(3);
        chk("rst_flags", {cmd_send, ready, init_fail, pkt_valid, sync_err, buttons, x_ovf, y_ovf}, 0);
        chk("rst_dx_dy", {dx, dy}, 0);
        chk("rst_cmd_data", cmd_data, 8'hF4);
        chk("rst_pos", {pos_x, pos_y}, {9'd160, 8'd120});
        rst = 1'b0;
        tick();
        chk("cmd_send_first", cmd_send, 1);
        k = 0;
        for (int i = 0; i < 9; i++) begin
            rx = 8'hFA;
            rx_en = (i == 4);
            tick();
            rx_en = 1'b0;
            k += int'(cmd_send);
        end
        chk("cmd_send_held", k, 9);
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        chk("cmd_send_drop", cmd_send, 0);
        tick(T);
        chk("ack_wait_not_ready", ready, 0);
        send(8'hFA);
        chk("ready_after_ack", ready, 1);

        pkt(8'h29, 8'h05, 8'hFE, 3'b001, 9'h005, 9'h1FE, 0, 0, 165, 122);
        send(8'h00);
        exp_sync++;
        pkt(8'h08, 8'h01, 8'h01, 3'b000, 9'h001, 9'h001, 0, 0, 166, 121);
        send(8'h08);
        tick(T + 1);
        exp_sync++;
        pkt(8'h18, 8'h10, 8'h00, 3'b000, 9'h110, 9'h000, 0, 0, 0, 121);
        push(3'b000, 9'h001, 9'h002, 0, 0, 1, 119);
        send(8'h08);
        tick(T);
        send(8'h01);
        tick(T);
        send(8'h02);
        pkt(8'h08, 8'hFF, 8'h00, 3'b000, 9'h0FF, 9'h000, 0, 0, 256, 119);
        pkt(8'h08, 8'hFF, 8'h00, 3'b000, 9'h0FF, 9'h000, 0, 0, 319, 119);
        pkt(8'h58, 8'h80, 8'h00, 3'b000, 9'h180, 9'h000, 1, 0, 319, 119);
        pkt(8'hA8, 8'h00, 8'h7F, 3'b000, 9'h000, 9'h17F, 0, 1, 319, 119);
        pkt(8'h28, 8'h00, 8'h01, 3'b000, 9'h000, 9'h101, 0, 0, 319, 239);
        pkt(8'h0F, 8'h02, 8'h00, 3'b111, 9'h002, 9'h000, 0, 0, 319, 239);
        pkt(8'h08, 8'h00, 8'hFF, 3'b000, 9'h000, 9'h0FF, 0, 0, 319, 0);
        tick(3);
        chk("sync_err_count", got_sync, exp_sync);
        chk("pkts_drained", q.size(), 0);

        send(8'h08);
        send(8'h01);
        rst = 1'b1;
        tick(2);
        chk("midpkt_rst_ready", ready, 0);
        chk("midpkt_rst_pos", {pos_x, pos_y}, {9'd160, 8'd120});
        rst = 1'b0;
        wait_send();
        for (int a = 1; a <= 3; a++) begin
            cmd_to = 1'b1;
            tick();
            cmd_to = 1'b0;
            chk("retry_gap", cmd_send, 0);
            if (a < 3) begin
                tick();
                chk("retry_resend", cmd_send, 1);
                chk("retry_not_failed", init_fail, 0);
            end
        end
        chk("init_fail_set", init_fail, 1);
        rx = 8'hFA;
        rx_en = 1'b1;
        cmd_sent = 1'b1;
        tick(3);
        rx_en = 1'b0;
        cmd_sent = 1'b0;
        tick(20);
        chk("fail_sticky", {init_fail, ready, cmd_send}, 3'b100);

        rst = 1'b1;
        tick(2);
        chk("init_fail_cleared", init_fail, 0);
        rst = 1'b0;
        wait_send();
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        send(8'h00);
        chk("ack_bad_gap", cmd_send, 0);
        tick();
        chk("ack_bad_resend", cmd_send, 1);
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        tick(T + 1);
        chk("ack_to_gap", {cmd_send, ready}, 0);
        tick();
        chk("ack_to_resend", cmd_send, 1);
        cmd_to = 1'b1;
        tick();
        cmd_to = 1'b0;
        chk("mixed_third_fail", init_fail, 1);
        tick(3);
        chk("no_stray_pkts", q.size(), 0);
        chk("sync_err_final", got_sync, exp_sync);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
